hier_fanout_node: RTL

- Parametrised hierarchy node that accepts requests from its parent and distributes them to NUM_CHILD child instances.
- Generalises the fixed five-child root into a configurable fan-out with a real request/acknowledge path.
- Two modes: round-robin dispatch (one child per request) or broadcast (every child receives each request).
- Tracks outstanding work per child, applies per-child backpressure, and reports completions back to the parent.

---
 rtl/hier_fanout_if.sv | 29 ++
 rtl/hier_fanout_node.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hier_fanout_if.sv
// Parent/child request bundle for hier_fanout_node.
// master = parent + children side, slave = the node.
interface hier_fanout_if #(
  parameter int unsigned NUM_CHILD = 5,
  parameter int unsigned DATA_W    = 16
);
  localparam int unsigned CNT_W = $clog2(NUM_CHILD + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic [NUM_CHILD-1:0] ch_valid;
  logic [NUM_CHILD-1:0] ch_ready;
  logic [DATA_W-1:0]    ch_data;
  logic [NUM_CHILD-1:0] ch_done;
  logic [CNT_W-1:0]     done_count;
  logic                 busy;
  logic                 err;

  modport master (
    output in_valid, in_data, ch_ready, ch_done,
    input  in_ready, ch_valid, ch_data, done_count, busy, err
  );

  modport slave (
    input  in_valid, in_data, ch_ready, ch_done,
    output in_ready, ch_valid, ch_data, done_count, busy, err
  );
endinterface

// File: rtl/hier_fanout_node.sv
// Hierarchy node: accepts one parent request at a time and dispatches it to
// NUM_CHILD children (round-robin or broadcast) with per-child credit tracking.
module hier_fanout_node #(
  parameter int unsigned NUM_CHILD       = 5,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          BROADCAST       = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  hier_fanout_if.slave   node_io
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_CHILD + 1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 lock_q, lock_d;
  logic [PTR_W-1:0]     lock_tgt_q, lock_tgt_d;
  logic [OUT_W-1:0]     outst_q [NUM_CHILD];
  logic [OUT_W-1:0]     outst_d [NUM_CHILD];
  logic [NUM_CHILD-1:0] pending_q, pending_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [CNT_W-1:0]     done_cnt_q, done_cnt_d;
  logic                 err_q, err_d;

  logic [NUM_CHILD-1:0] elig;
  logic [NUM_CHILD-1:0] nonzero;
  logic [NUM_CHILD-1:0] ch_valid_c;
  logic [NUM_CHILD-1:0] hs;
  logic [NUM_CHILD-1:0] done_ok;
  logic [PTR_W-1:0]     tgt;
  logic                 tgt_found;
  int unsigned          rr_idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CHILD; i++) begin
      elig[i]    = outst_q[i] < OUT_W'(MAX_OUTSTANDING);
      nonzero[i] = outst_q[i] != '0;
    end
  end

  // Round-robin target: first eligible child at/after rr_ptr; a target already
  // offered to a stalled child stays locked until it handshakes.
  always_comb begin
    tgt       = '0;
    tgt_found = 1'b0;
    rr_idx    = 0;
    for (int unsigned k = 0; k < NUM_CHILD; k++) begin
      rr_idx = 32'(rr_ptr_q) + k;
      if (rr_idx >= NUM_CHILD) rr_idx = rr_idx - NUM_CHILD;
      if (!tgt_found && elig[PTR_W'(rr_idx)]) begin
        tgt       = PTR_W'(rr_idx);
        tgt_found = 1'b1;
      end
    end
    if (lock_q) begin
      tgt       = lock_tgt_q;
      tgt_found = 1'b1;
    end
  end

  always_comb begin
    ch_valid_c = '0;
    if (state_q == ISSUE) begin
      if (BROADCAST) ch_valid_c = pending_q & elig;
      else if (tgt_found) ch_valid_c[tgt] = 1'b1;
    end
  end

  assign hs      = ch_valid_c & node_io.ch_ready;
  assign done_ok = node_io.ch_done & nonzero;

  // Next-state, credit and completion accounting.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_tgt_d = lock_tgt_q;
    pending_d  = pending_q;
    data_d     = data_q;
    err_d      = err_q | (|(node_io.ch_done & ~nonzero));
    done_cnt_d = '0;

    for (int unsigned i = 0; i < NUM_CHILD; i++) begin
      done_cnt_d = done_cnt_d + CNT_W'(done_ok[i]);
      case ({hs[i], done_ok[i]})
        2'b10:   outst_d[i] = outst_q[i] + OUT_W'(1);
        2'b01:   outst_d[i] = outst_q[i] - OUT_W'(1);
        default: outst_d[i] = outst_q[i];
      endcase
    end

    case (state_q)
      IDLE: begin
        if (node_io.in_valid) begin
          data_d    = node_io.in_data;
          state_d   = ISSUE;
          lock_d    = 1'b0;
          pending_d = BROADCAST ? '1 : '0;
        end
      end
      ISSUE: begin
        if (BROADCAST) begin
          pending_d = pending_q & ~hs;
          if (pending_d == '0) state_d = IDLE;
        end else if (|hs) begin
          rr_ptr_d = (tgt == PTR_W'(NUM_CHILD - 1)) ? '0 : tgt + PTR_W'(1);
          lock_d   = 1'b0;
          state_d  = IDLE;
        end else if (tgt_found) begin
          lock_d     = 1'b1;
          lock_tgt_d = tgt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_tgt_q <= '0;
      pending_q  <= '0;
      data_q     <= '0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_CHILD; i++) outst_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_tgt_q <= lock_tgt_d;
      pending_q  <= pending_d;
      data_q     <= data_d;
      done_cnt_q <= done_cnt_d;
      err_q      <= err_d;
      for (int unsigned i = 0; i < NUM_CHILD; i++) outst_q[i] <= outst_d[i];
    end
  end

  assign node_io.in_ready   = (state_q == IDLE);
  assign node_io.ch_valid   = ch_valid_c;
  assign node_io.ch_data    = data_q;
  assign node_io.done_count = done_cnt_q;
  assign node_io.busy       = (state_q != IDLE) || (|nonzero);
  assign node_io.err        = err_q;

endmodule
